// File: rtl/pipe_reg_chain_if.sv
// Valid/ready bundle for both ends of pipe_reg_chain: upstream (in_*) and downstream (out_*).
// The slave modport is the pipeline's view; master is the surrounding logic's view.
interface pipe_reg_chain_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline of DEPTH valid/ready register stages with per-stage stall,
// bubble collapse, synchronous flush and a registered occupancy count.
module pipe_reg_chain #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  pipe_reg_chain_if.slave     bus,
  output logic [CW-1:0]       occupancy
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    occ_q;
  logic [CW-1:0]    occ_d;
  logic [DEPTH-1:0] rdy;

  // A stage can move when any stage from it to the output is empty, or the
  // consumer is taking the head; this is the unrolled form of the ready chain.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rdy
    assign rdy[gi] = bus.out_ready | ~(&v_q[DEPTH-1:gi]);
  end

  always_comb begin
    v_d   = v_q;
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        v_d[i] = 1'b0;
      end else if (rdy[i]) begin
        if (i == 0) begin
          v_d[i] = bus.in_valid;
          if (bus.in_valid) d_d[i] = bus.in_data;
        end else begin
          v_d[i] = v_q[i-1];
          // Bubbles advance only their valid bit; payload keeps the last real entry.
          if (v_q[i-1]) d_d[i] = d_q[i-1];
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + CW'(v_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign bus.in_ready  = rdy[0] & ~flush;
  assign bus.out_valid = v_q[DEPTH-1] & ~flush;
  assign bus.out_data  = d_q[DEPTH-1];
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (DEPTH=4/WIDTH=64 and DEPTH=1/WIDTH=8) with
// queue scoreboards popped by per-DUT output monitors.
module tb_pipe_reg_chain;

  logic clk = 1'b0;
  logic reset;
  logic flush_a;
  logic flush_b;
  logic [2:0] occ_a;
  logic [0:0] occ_b;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_a [$];
  logic [63:0] exp_b [$];

  pipe_reg_chain_if #(.WIDTH(64)) a_if ();
  pipe_reg_chain_if #(.WIDTH(8))  b_if ();

  pipe_reg_chain #(.WIDTH(64), .DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .flush(flush_a), .bus(a_if.slave), .occupancy(occ_a)
  );

  pipe_reg_chain #(.WIDTH(8), .DEPTH(1)) dut_b (
    .clk(clk), .reset(reset), .flush(flush_b), .bus(b_if.slave), .occupancy(occ_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && a_if.out_valid && a_if.out_ready) begin
      if (exp_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_out actual=%0h required=none", a_if.out_data);
      end else begin
        chk("a_out_data", a_if.out_data, exp_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b_if.out_valid && b_if.out_ready) begin
      if (exp_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_out actual=%0h required=none", b_if.out_data);
      end else begin
        chk("b_out_data", 64'(b_if.out_data), exp_b.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input bit b, input logic v, input logic [63:0] d);
    if (b) begin
      b_if.in_valid = v;
      b_if.in_data  = d[7:0];
    end else begin
      a_if.in_valid = v;
      a_if.in_data  = d;
    end
  endtask

  task automatic set_out_ready(input bit b, input logic r);
    if (b) b_if.out_ready = r;
    else   a_if.out_ready = r;
  endtask

  task automatic push(input bit b, input logic [63:0] d);
    if (b) exp_b.push_back(d);
    else   exp_a.push_back(d);
  endtask

  function automatic logic rd_in_ready(input bit b);
    return b ? b_if.in_ready : a_if.in_ready;
  endfunction

  function automatic logic rd_out_valid(input bit b);
    return b ? b_if.out_valid : a_if.out_valid;
  endfunction

  function automatic logic [63:0] rd_occ(input bit b);
    return b ? 64'(occ_b) : 64'(occ_a);
  endfunction

  function automatic string nm(input bit b, input string s);
    return $sformatf("%s_%s", b ? "b" : "a", s);
  endfunction

  // Sends 1..n back to back with out_ready high; checks throughput, latency, occupancy.
  task automatic stream(input bit b, input int n, input int depth);
    int acc_cyc;
    int first_cyc;
    acc_cyc   = 0;
    first_cyc = -1;
    set_out_ready(b, 1'b1);
    for (int k = 1; k <= n; k++) begin
      drive_in(b, 1'b1, 64'(k));
      @(negedge clk);
      chk(nm(b, "stream_in_ready"), 64'(rd_in_ready(b)), 64'd1);
      push(b, 64'(k));
      if (k == 1) acc_cyc = cyc;
      if (first_cyc < 0 && rd_out_valid(b)) first_cyc = cyc;
      if (k == 8) chk(nm(b, "stream_occupancy"), rd_occ(b), 64'(depth));
      step();
    end
    drive_in(b, 1'b0, 64'd0);
    chk(nm(b, "stream_latency"), 64'(first_cyc - acc_cyc), 64'(depth));
  endtask

  task automatic wait_drain(input bit b);
    for (int i = 0; i < 40; i++) begin
      if ((b ? exp_b.size() : exp_a.size()) == 0) break;
      step();
    end
    chk(nm(b, "drain_left"), 64'(b ? exp_b.size() : exp_a.size()), 64'd0);
  endtask

  // Accepts one value on stage 0; optionally records it as an expected output.
  task automatic accept(input logic [63:0] d, input bit keep);
    drive_in(0, 1'b1, d);
    @(negedge clk);
    chk($sformatf("a_accept_%0h_in_ready", d), 64'(a_if.in_ready), 64'd1);
    if (keep) push(0, d);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    flush_a = 1'b0;
    flush_b = 1'b0;
    drive_in(0, 1'b1, 64'hAA);
    drive_in(1, 1'b1, 64'hAA);
    set_out_ready(0, 1'b1);
    set_out_ready(1, 1'b1);
    step();
    step();
    @(negedge clk);
    chk("a_reset_out_valid", 64'(a_if.out_valid), 64'd0);
    chk("a_reset_out_data", a_if.out_data, 64'd0);
    chk("a_reset_occupancy", 64'(occ_a), 64'd0);
    chk("b_reset_out_valid", 64'(b_if.out_valid), 64'd0);
    chk("b_reset_out_data", 64'(b_if.out_data), 64'd0);
    step();
    reset = 1'b0;
    drive_in(0, 1'b0, 64'd0);
    drive_in(1, 1'b0, 64'd0);
    @(negedge clk);
    chk("a_release_in_ready", 64'(a_if.in_ready), 64'd1);
    chk("b_release_in_ready", 64'(b_if.in_ready), 64'd1);
    step();

    stream(0, 10, 4);
    wait_drain(0);

    // Bubble collapse under a stalled consumer.
    set_out_ready(0, 1'b0);
    accept(64'hA, 1'b1);
    drive_in(0, 1'b0, 64'd0);
    step();
    step();
    accept(64'hB, 1'b1);
    drive_in(0, 1'b0, 64'd0);
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    chk("a_bubble_occupancy", 64'(occ_a), 64'd2);
    chk("a_bubble_valid_map", 64'(dut_a.v_q), 64'b1100);
    chk("a_bubble_stage2_data", dut_a.d_q[2], 64'hB);
    chk("a_bubble_out_data", a_if.out_data, 64'hA);
    step();
    set_out_ready(0, 1'b1);
    wait_drain(0);

    // Back-pressure: four fit, the fifth waits until the consumer returns.
    set_out_ready(0, 1'b0);
    for (int i = 0; i < 4; i++) accept(64'h10 + 64'(i), 1'b1);
    drive_in(0, 1'b1, 64'h14);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("a_full_in_ready", 64'(a_if.in_ready), 64'd0);
      chk("a_full_occupancy", 64'(occ_a), 64'd4);
      chk("a_full_out_data", a_if.out_data, 64'h10);
      step();
    end
    set_out_ready(0, 1'b1);
    @(negedge clk);
    chk("a_full_ready_passthru", 64'(a_if.in_ready), 64'd1);
    push(0, 64'h14);
    step();
    drive_in(0, 1'b1, 64'h15);
    @(negedge clk);
    chk("a_full_inout_occupancy", 64'(occ_a), 64'd4);
    chk("a_h15_in_ready", 64'(a_if.in_ready), 64'd1);
    push(0, 64'h15);
    step();
    drive_in(0, 1'b0, 64'd0);
    wait_drain(0);

    // Flush with three entries in flight; none of them nor the flush-cycle input may emerge.
    set_out_ready(0, 1'b0);
    accept(64'h21, 1'b0);
    accept(64'h22, 1'b0);
    accept(64'h23, 1'b0);
    drive_in(0, 1'b0, 64'd0);
    step();
    @(negedge clk);
    chk("a_preflush_occupancy", 64'(occ_a), 64'd3);
    step();
    flush_a = 1'b1;
    set_out_ready(0, 1'b1);
    drive_in(0, 1'b1, 64'h99);
    @(negedge clk);
    chk("a_flush_in_ready", 64'(a_if.in_ready), 64'd0);
    chk("a_flush_out_valid", 64'(a_if.out_valid), 64'd0);
    step();
    flush_a = 1'b0;
    drive_in(0, 1'b0, 64'd0);
    @(negedge clk);
    chk("a_postflush_occupancy", 64'(occ_a), 64'd0);
    chk("a_postflush_out_valid", 64'(a_if.out_valid), 64'd0);
    for (int i = 0; i < 8; i++) step();

    // Reset with a full pipe while out_ready toggles.
    set_out_ready(0, 1'b0);
    for (int i = 0; i < 4; i++) accept(64'h31 + 64'(i), 1'b0);
    drive_in(0, 1'b0, 64'd0);
    @(negedge clk);
    chk("a_prereset_occupancy", 64'(occ_a), 64'd4);
    step();
    reset = 1'b1;
    set_out_ready(0, 1'b1);
    drive_in(0, 1'b1, 64'h77);
    step();
    reset = 1'b0;
    set_out_ready(0, 1'b0);
    drive_in(0, 1'b0, 64'd0);
    @(negedge clk);
    chk("a_midreset_occupancy", 64'(occ_a), 64'd0);
    chk("a_midreset_out_data", a_if.out_data, 64'd0);
    chk("a_midreset_out_valid", 64'(a_if.out_valid), 64'd0);
    step();

    stream(1, 10, 1);
    wait_drain(1);
    for (int i = 0; i < 4; i++) step();
    chk("a_final_queue", 64'(exp_a.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
